// File: rtl/binary_sign_packer.sv
// Binarizing producer: turns signed values into +1/-1 sign bits and packs them LSB-first.
// Optional macro BIN_THRESHOLD_EN adds a per-beat signed threshold input (i_threshold).
module binary_sign_packer #(
  parameter int BitSize   = 32,
  parameter int PackWidth = 8,
  localparam int CntW     = $clog2(PackWidth + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [BitSize-1:0]  in_data,
  input  logic                       in_last,
`ifdef BIN_THRESHOLD_EN
  input  logic signed [BitSize-1:0]  i_threshold,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PackWidth-1:0]       out_data,
  output logic [CntW-1:0]            out_count
);

  typedef enum logic {IDLE, FILL} state_t;

  localparam logic [CntW-1:0] FULL = CntW'(PackWidth);

  // 1 encodes multiply-by-+1, 0 encodes multiply-by--1; zero maps to +1.
  function automatic logic sign_bit(input logic signed [BitSize-1:0] v,
                                    input logic signed [BitSize-1:0] t);
    return v >= t;
  endfunction

  state_t                    state;
  logic [CntW-1:0]           cnt;
  logic [CntW-1:0]           cnt_nxt;
  logic [CntW-1:0]           wr_pos;
  logic [PackWidth-1:0]      sreg_p0;
  logic [PackWidth-1:0]      sreg_nxt;
  logic signed [BitSize-1:0] thr;
  logic                      accept;
  logic                      consume;
  logic                      done;

`ifdef BIN_THRESHOLD_EN
  assign thr = i_threshold;
`else
  assign thr = '0;
`endif

  assign in_ready = !out_valid || out_ready;

  always_comb begin
    accept   = in_valid && in_ready;
    consume  = out_valid && out_ready;
    wr_pos   = (state == IDLE) ? '0 : cnt;
    cnt_nxt  = wr_pos + CntW'(1);
    sreg_nxt = sreg_p0 | (PackWidth'(sign_bit(in_data, thr)) << wr_pos);
    done     = accept && (in_last || (cnt_nxt == FULL));
  end

  // Stage p0 (fill shift register) -> output word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg_p0   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (consume && !done)
        out_valid <= 1'b0;
      if (accept) begin
        if (done) begin
          out_data  <= sreg_nxt;
          out_count <= cnt_nxt;
          out_valid <= 1'b1;
          cnt       <= '0;
          sreg_p0   <= '0;
          state     <= IDLE;
        end else begin
          cnt       <= cnt_nxt;
          sreg_p0   <= sreg_nxt;
          state     <= FILL;
        end
      end
    end
  end

endmodule

// File: tb/tb_binary_sign_packer.sv
// Directed bench for binary_sign_packer (BitSize=32, PackWidth=8).
module tb_binary_sign_packer;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] in_data;
  logic               in_last;
`ifdef BIN_THRESHOLD_EN
  logic signed [31:0] i_threshold;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [7:0]         out_data;
  logic [3:0]         out_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  binary_sign_packer #(.BitSize(32), .PackWidth(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
`ifdef BIN_THRESHOLD_EN
    .i_threshold(i_threshold),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_count(out_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one beat at the falling edge; in_ready is expected high for every call.
  task automatic send(input int d, input logic l);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    #1;
    check("in_ready_beat", in_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [7:0] d, input logic [3:0] c);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, d);
    check({tag, "_count"}, out_count, c);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef BIN_THRESHOLD_EN
    i_threshold = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_count", out_count, 4'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;

    // Full word with no stall: 5,-3,0,-1,7,-128,2,-2 -> 0x55
    send(5, 0); send(-3, 0); send(0, 0); send(-1, 0);
    send(7, 0); send(-128, 0); send(2, 0);
    check("full_early_valid", out_valid, 1'b0);
    send(-2, 0);
    check_word("full", 8'h55, 4'd8);
    idle();
    check("full_release_valid", out_valid, 1'b0);
    check("full_release_hold", out_data, 8'h55);

    // Partial flush: -4,9,-1 last -> 0b010, then next word restarts at bit 0
    send(-4, 0); send(9, 0); send(-1, 1);
    check_word("partial", 8'h02, 4'd3);
    send(3, 0); send(-5, 1);
    check_word("partial_next", 8'h01, 4'd2);
    idle();

    // Extremes: most negative -> 0, most positive -> 1
    send(32'sh80000000, 0); send(32'sh7FFFFFFF, 1);
    check_word("extreme", 8'h02, 4'd2);
    idle();

    // Backpressure: word 0x7E held for 4 cycles while a beat waits
    out_ready = 1'b0;
    send(-1, 0); send(1, 0); send(1, 0); send(1, 0);
    send(1, 0); send(1, 0); send(1, 0); send(-1, 0);
    check_word("bp_done", 8'h7E, 4'd8);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 9;
      in_last  = 1'b1;
      #1;
      check("bp_in_ready", in_ready, 1'b0);
      check_word("bp_hold", 8'h7E, 4'd8);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check_word("bp_pending_beat", 8'h01, 4'd1);
    idle();
    check("bp_drain_valid", out_valid, 1'b0);
    check("bp_drain_hold", out_data, 8'h01);

    // Back-to-back: 16 alternating +1/-1 -> two 0x55 words, no bubble
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? 1 : -1, 0);
    check_word("b2b_w0", 8'h55, 4'd8);
    send(1, 0);
    check("b2b_mid_valid", out_valid, 1'b0);
    for (int i = 1; i < 8; i++) send((i % 2 == 0) ? 1 : -1, 0);
    check_word("b2b_w1", 8'h55, 4'd8);
    idle();

    // Reset after 5 accepted beats discards the partial word
    send(-1, 0); send(-2, 0); send(-3, 0); send(-4, 0); send(-5, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_count", out_count, 4'd0);
    check("midrst_data", out_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    send(1, 0); send(2, 0); send(3, 0);
    check("postrst_early_valid", out_valid, 1'b0);
    send(0, 0); send(100, 0); send(7, 0); send(8, 0); send(9, 0);
    check_word("postrst", 8'hFF, 4'd8);
    idle();

`ifdef BIN_THRESHOLD_EN
    // Threshold 10: 10,9,-20,11 last -> 0b1001
    i_threshold = 10;
    send(10, 0); send(9, 0); send(-20, 0); send(11, 1);
    check_word("thresh", 8'h09, 4'd4);
    idle();
    i_threshold = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/binary_sign_packer.md
Name: binary_sign_packer

Overview:
- Binarizing producer for the 1-bit weight/activation path.
- Converts a stream of signed BitSize-bit values into sign bits, using the existing +1/-1 encoding: 1 means multiply by +1, 0 means multiply by -1.
- Packs the bits LSB-first into PackWidth-bit words with valid/ready handshakes on both sides.
- Sits between the accumulator/activation stage and the buffers that feed the 1-bit multiplier array's select inputs.

Parameters:
- BitSize, 32, width of the signed input values.
- PackWidth, 8, number of sign bits per output word (minimum 2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  BitSize  signed two's-complement value.
- in_last  in  1  final value of the group; flushes a partial word.
- out_valid  out  1  out_data/out_count hold a word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  PackWidth  packed sign bits; bit 0 is the oldest value.
- out_count  out  $clog2(PackWidth+1)  number of valid bits in out_data (1..PackWidth).

Behaviour:
- Reset:
  - out_valid=0, out_data=0, out_count=0.
  - Internal fill counter cnt=0, shift register=0, FSM=IDLE.
  - A reset mid-word discards the partial word and any held output word.
- Sign rule:
  - bit = 1 when in_data >= 0, so zero maps to +1.
  - bit = 0 when in_data < 0, including the most negative value.
  - Only the MSB of in_data is examined (absent BIN_THRESHOLD_EN).
- Handshake:
  - A beat is accepted when in_valid && in_ready.
  - A word is consumed when out_valid && out_ready.
  - in_ready = !out_valid || out_ready. This is combinational from out_ready and never depends on in_valid, in_data or in_last.
  - in_valid low: no state change.
- Accept a beat:
  - Write the bit at position cnt, then cnt increments.
  - If the new cnt == PackWidth or in_last=1, the word is completed:
    - the shift register transfers to the output register;
    - out_count = new cnt;
    - out_valid=1 on the next cycle;
    - cnt and the shift register clear.
  - Bits at or above out_count in a partial word are 0.
- Latency: one cycle from the accepting edge of the completing beat to out_valid high.
- Throughput: one beat per cycle while out_ready is held high. A word can complete on the same cycle the previous word is consumed.
- Output hold: while out_valid && !out_ready, out_data and out_count are stable and in_ready=0.
- Output release: consume without a new completion sets out_valid=0; out_data holds its last value.
- FSM:
  - IDLE (cnt=0) -> FILL on an accepted beat without completion.
  - FILL -> IDLE on completion (full or in_last).
  - in_last on the first beat produces out_count=1.
- Width rules:
  - cnt width is $clog2(PackWidth+1).
  - No arithmetic on in_data beyond the comparison.

Optional Feature:
- Macro: BIN_THRESHOLD_EN.
- Defined:
  - Adds port i_threshold, input, signed BitSize bits, sampled with each accepted beat.
  - bit = (in_data >= i_threshold), signed compare. Used for folded batch-norm thresholds.
- Undefined:
  - No extra port; threshold is fixed at 0 (sign-bit rule above).
  - Logic is identical otherwise.

Test Plan:
- Full word, no stall: PackWidth=8, out_ready=1, inputs 5,-3,0,-1,7,-128,2,-2.
  - Expect out_data=8'b0101_0101, out_count=8.
  - out_valid high exactly one cycle after the 8th accept; in_ready constantly 1.
- Partial flush: inputs -4,9,-1 with in_last on the third.
  - Expect out_data=8'b0000_0010, out_count=3; the next word starts at bit 0.
- Backpressure: complete a word, hold out_ready=0 for 4 cycles.
  - Expect out_valid=1, out_data stable, in_ready=0 throughout.
  - Raising out_ready restores in_ready in the same cycle with no data lost.
- Back-to-back words: 16 consecutive inputs alternating 1,-1 with out_ready=1.
  - Expect two words of 8'h55 on consecutive word boundaries with no bubble.
- Reset mid-operation: assert rst after 5 accepted beats.
  - Expect immediate out_valid=0, out_count=0.
  - Subsequent 8 positive inputs produce 8'hFF with out_count=8.
- BIN_THRESHOLD_EN, i_threshold=10: inputs 10,9,-20,11 with in_last on the last.
  - Expect out_data=8'b0000_1001, out_count=4.
